dp_arb: RTL and testbench

//   Parametrised, registered dual-priority arbiter: each accepted cycle grants the two

---
 rtl/dp_arb_pkg.sv | 13 +
 rtl/dp_arb_rot_enc.sv | 48 ++++
 rtl/dp_arb.sv | 72 +++++++
 tb/tb_dp_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dp_arb_pkg.sv
// Shared defaults and helpers for the dual-priority arbiter.
// Index 0 encodes "no request"; valid request indices run 1..N.
package dp_arb_pkg;

    localparam int unsigned DP_N_DEF = 12;
    localparam int unsigned DP_NONE  = 0;

    // Pointer wrap: index 0 folds back to the top index n.
    function automatic int unsigned dp_wrap(input int unsigned v, input int unsigned n);
        return (v == 0) ? n : v;
    endfunction

endpackage

// File: rtl/dp_arb_rot_enc.sv
// Combinational dual-priority encoder.
// Rotates req so that index ptr lands on the top bit, picks the two highest set bits, then maps them back to indices.
module dp_rot_enc
    import dp_arb_pkg::*;
#(
    parameter int unsigned N    = DP_N_DEF,
    parameter int unsigned IDXW = $clog2(N + 1)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] first,
    output logic [IDXW-1:0] second
);

    logic [N-1:0] w_rot;

    // w_rot[k] = req[(k + ptr) mod N], so w_rot[N-1] is request index ptr.
    always_comb begin
        w_rot = '0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (i == ((k + int'(ptr)) % N)) w_rot[k] = req[i];
            end
        end
    end

    always_comb begin
        int unsigned h1;
        int unsigned h2;
        logic        h1v;
        logic        h2v;
        h1  = 0;
        h2  = 0;
        h1v = 1'b0;
        h2v = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (w_rot[k]) begin
                h2  = h1;
                h2v = h1v;
                h1  = k;
                h1v = 1'b1;
            end
        end
        first  = h1v ? IDXW'(((h1 + int'(ptr)) % N) + 1) : IDXW'(DP_NONE);
        second = h2v ? IDXW'(((h2 + int'(ptr)) % N) + 1) : IDXW'(DP_NONE);
    end

endmodule

// File: rtl/dp_arb.sv
// Registered dual-priority arbiter: grants the two highest-priority requests per accepted cycle.
// Fixed (RR=0) or round-robin (RR=1) priority; grant pair held under valid/ack handshake.
module dp_arb
    import dp_arb_pkg::*;
#(
    parameter int unsigned N    = DP_N_DEF,
    parameter int unsigned IDXW = $clog2(N + 1),
    parameter int unsigned RR   = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            ack,
    output logic            valid,
    output logic [IDXW-1:0] first,
    output logic [IDXW-1:0] second
);

    logic            r_valid;
    logic [IDXW-1:0] r_first;
    logic [IDXW-1:0] r_second;
    logic [IDXW-1:0] r_ptr;

    logic            w_acc;
    logic            w_ld;
    logic [IDXW-1:0] w_base;
    logic [IDXW-1:0] w_ptr_nxt;
    logic [IDXW-1:0] w_first;
    logic [IDXW-1:0] w_second;

    assign w_acc = r_valid & ack;
    assign w_ld  = ~r_valid | ack;

    // The pointer moves past the last granted index, and the same edge loads from the moved pointer.
    always_comb begin
        w_base    = (r_second != '0) ? r_second : r_first;
        w_ptr_nxt = r_ptr;
        if (RR != 0 && w_acc)
            w_ptr_nxt = IDXW'(dp_wrap(int'(w_base) - 1, N));
    end

    dp_rot_enc #(
        .N    (N),
        .IDXW (IDXW)
    ) u_enc (
        .req    (req),
        .ptr    (w_ptr_nxt),
        .first  (w_first),
        .second (w_second)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_first  <= '0;
            r_second <= '0;
            r_ptr    <= IDXW'(N);
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_ld) begin
                r_valid  <= |req;
                r_first  <= w_first;
                r_second <= w_second;
            end
        end
    end

    assign valid  = r_valid;
    assign first  = r_first;
    assign second = r_second;

endmodule

// File: tb/tb_dp_arb.sv
// Bench for dp_arb: fixed and round-robin instances driven in parallel, scored against a scan-order model.
module tb_dp_arb;

    localparam int N = 12;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic         ack;

    logic         fx_valid, rr_valid;
    logic [W-1:0] fx_first, fx_second, rr_first, rr_second;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        int v0; int f0; int s0;
        int v1; int f1; int s1;
    } exp_t;

    exp_t q[$];

    int m_v[2], m_f[2], m_s[2], m_p[2];

    always #5 clk = ~clk;

    dp_arb #(.N(N), .IDXW(W), .RR(0)) u_fx (
        .clk(clk), .reset(reset), .req(req), .ack(ack),
        .valid(fx_valid), .first(fx_first), .second(fx_second)
    );

    dp_arb #(.N(N), .IDXW(W), .RR(1)) u_rr (
        .clk(clk), .reset(reset), .req(req), .ack(ack),
        .valid(rr_valid), .first(rr_first), .second(rr_second)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic void scan(input logic [N-1:0] r, input int p, output int f, output int s);
        f = 0;
        s = 0;
        for (int j = 0; j < N; j++) begin
            int idx;
            idx = p - j;
            if (idx <= 0) idx += N;
            if (r[idx-1]) begin
                if (f == 0) f = idx;
                else if (s == 0) s = idx;
            end
        end
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_v[i] = 0; m_f[i] = 0; m_s[i] = 0; m_p[i] = N;
            end else begin
                int pn;
                int b;
                pn = m_p[i];
                if (i == 1 && m_v[i] == 1 && ack) begin
                    b  = (m_s[i] != 0) ? m_s[i] : m_f[i];
                    pn = (b - 1 == 0) ? N : b - 1;
                end
                if (m_v[i] == 0 || ack) begin
                    scan(req, pn, m_f[i], m_s[i]);
                    m_v[i] = (req != '0) ? 1 : 0;
                end
                m_p[i] = pn;
            end
        end
    endtask

    // Advance one clock: push the model's prediction, then pop and score it after the edge.
    task automatic step();
        exp_t e;
        model_step();
        e.v0 = m_v[0]; e.f0 = m_f[0]; e.s0 = m_s[0];
        e.v1 = m_v[1]; e.f1 = m_f[1]; e.s1 = m_s[1];
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("fx.valid",  int'(fx_valid),  e.v0);
        check("fx.first",  int'(fx_first),  e.f0);
        check("fx.second", int'(fx_second), e.s0);
        check("rr.valid",  int'(rr_valid),  e.v1);
        check("rr.first",  int'(rr_first),  e.f1);
        check("rr.second", int'(rr_second), e.s1);
        check("fx.inv", ((fx_valid && fx_first == 0) || (fx_first != 0 && fx_first == fx_second)) ? 1 : 0, 0);
        check("rr.inv", ((rr_valid && rr_first == 0) || (rr_first != 0 && rr_first == rr_second)) ? 1 : 0, 0);
    endtask

    task automatic expect_out(input string tag, input int inst, input int v, input int f, input int s);
        if (inst == 0) begin
            check({tag, ".v"}, int'(fx_valid),  v);
            check({tag, ".f"}, int'(fx_first),  f);
            check({tag, ".s"}, int'(fx_second), s);
        end else begin
            check({tag, ".v"}, int'(rr_valid),  v);
            check({tag, ".f"}, int'(rr_first),  f);
            check({tag, ".s"}, int'(rr_second), s);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 12'hFFF;
        ack   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 0; m_f[i] = 0; m_s[i] = 0; m_p[i] = N;
        end

        // Reset held two cycles with all requests active.
        step(); step();
        expect_out("rst_fx", 0, 0, 0, 0);
        expect_out("rst_rr", 1, 0, 0, 0);
        reset = 1'b0; ack = 1'b1;
        step();
        expect_out("first_fx", 0, 1, 12, 11);
        expect_out("first_rr", 1, 1, 12, 11);

        // Fixed priority patterns.
        req = 12'hC00; step(); expect_out("fix_c00", 0, 1, 12, 11);
        req = 12'h801; step(); expect_out("fix_801", 0, 1, 12, 1);
        req = 12'h003; step(); expect_out("fix_003", 0, 1, 2, 1);
        req = 12'h001; step(); expect_out("fix_001", 0, 1, 1, 0);
        req = 12'h000; step(); expect_out("fix_000", 0, 0, 0, 0);

        // Hold: grant frozen while ack is low, even as req changes.
        req = 12'hC00; step(); expect_out("hold_ld", 0, 1, 12, 11);
        ack = 1'b0; req = 12'h001;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("hold", 0, 1, 12, 11);
        end
        ack = 1'b1; step(); expect_out("hold_rel", 0, 1, 1, 0);

        // Round-robin sweep from a fresh pointer.
        reset = 1'b1; step();
        reset = 1'b0; req = 12'hFFF; ack = 1'b1;
        step(); expect_out("rr0", 1, 1, 12, 11);
        step(); expect_out("rr1", 1, 1, 10, 9);
        step(); expect_out("rr2", 1, 1, 8, 7);
        step(); expect_out("rr3", 1, 1, 6, 5);
        step(); expect_out("rr4", 1, 1, 4, 3);
        step(); expect_out("rr5", 1, 1, 2, 1);
        step(); expect_out("rr6", 1, 1, 12, 11);

        // Wrap: pointer at 2 after (4,3), then sparse request set.
        step(); step(); step();
        step(); expect_out("rr_43", 1, 1, 4, 3);
        req = 12'h80A;
        step(); expect_out("wrap_a", 1, 1, 2, 12);
        step(); expect_out("wrap_b", 1, 1, 4, 2);

        // Reset while a grant is pending and unacknowledged.
        req = 12'hFFF; step();
        ack = 1'b0; step();
        reset = 1'b1; step();
        expect_out("mid_rst", 1, 0, 0, 0);
        reset = 1'b0; ack = 1'b1;
        step(); expect_out("mid_rel", 1, 1, 12, 11);

        // Random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            reset = ($urandom_range(0, 29) == 0);
            req   = N'($urandom) & N'($urandom);
            ack   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
